mandel_dispatch: RTL
====================

MANDEL_DISPATCH -- requirements
Module: mandel_dispatch

Interface
REQ-001 SHALL have parameter FB_WIDTH, default 320, meaning pixels per row.
REQ-002 SHALL have parameter FB_HEIGHT, default 180, meaning rows per frame.
REQ-003 SHALL have parameter ITERW, default 8, meaning iteration-count width in bits.
REQ-004 SHALL have parameter ADDRW, default $clog2(FB_WIDTH*FB_HEIGHT), meaning framebuffer address width.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk, input, 1 bit, the single clock.
REQ-007 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-008 SHALL have port frame_start, input, 1 bit, request to render one frame.
REQ-009 SHALL have port re_start, input, signed 25 bits, Q4.21 real coordinate of pixel (0,0).
REQ-010 SHALL have port im_start, input, signed 25 bits, Q4.21 imaginary coordinate of pixel (0,0).
REQ-011 SHALL have port step, input, signed 25 bits, Q4.21 coordinate distance between adjacent pixels.
REQ-012 SHALL have port eng_start, output, 1 bit, start pulse to the iteration engine.
REQ-013 SHALL have ports eng_re and eng_im, output, signed 25 bits each, coordinate presented to the engine.
REQ-014 SHALL have port eng_iter, input, ITERW bits, engine iteration result.
REQ-015 SHALL have port eng_done, input, 1 bit, engine completion pulse.
REQ-016 SHALL have ports fb_we (output, 1 bit), fb_addr (output, ADDRW bits) and fb_data (output, ITERW bits), the framebuffer write port.
REQ-017 SHALL have ports busy (output, 1 bit, frame in progress) and frame_done (output, 1 bit, one-cycle end-of-frame pulse).

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, WRITE and ADVANCE.
REQ-019 In IDLE with frame_start=1, SHALL latch re_start/im_start/step, set pixel counters x=0, y=0 and fb_addr=0, assert busy, and go to ISSUE.
REQ-020 In ISSUE, SHALL drive eng_start=1 for exactly one cycle, with eng_re/eng_im holding the current pixel coordinate, and go to WAIT.
REQ-021 eng_re/eng_im SHALL remain stable from ISSUE until the next ADVANCE.
REQ-022 In WAIT, SHALL hold until eng_done=1, then register eng_iter into fb_data and go to WRITE.
REQ-023 eng_done SHALL be ignored in every state other than WAIT.
REQ-024 In WRITE, SHALL assert fb_we for exactly one cycle with the current fb_addr/fb_data, then go to ADVANCE.
REQ-025 ADVANCE, when x<FB_WIDTH-1: SHALL set x+=1, eng_re+=step and fb_addr+=1, then go to ISSUE.
REQ-026 ADVANCE, at row end when y<FB_HEIGHT-1: SHALL set x=0, y+=1, eng_re=latched re_start, eng_im-=step and fb_addr+=1, then go to ISSUE.
REQ-027 ADVANCE, at the last pixel: SHALL pulse frame_done for one cycle, deassert busy, and go to IDLE.
REQ-028 Coordinate add/subtract SHALL be 25-bit two's complement with wrap and no saturation.
REQ-029 frame_start SHALL be ignored while busy=1.
REQ-030 Latency SHALL be engine latency + 4 cycles per pixel (ISSUE, WRITE, ADVANCE, plus the eng_done cycle).
REQ-031 A frame_start asserted in the same cycle frame_done pulses SHALL be ignored; a new frame starts no earlier than the following IDLE cycle.

Reset
REQ-032 rst SHALL force IDLE and set eng_start=0, fb_we=0, frame_done=0, busy=0, fb_addr=0, fb_data=0, eng_re=0 and eng_im=0.
REQ-033 rst mid-frame SHALL abort with no further fb_we or eng_start; the engine is reset by the same rst.
REQ-034 rst SHALL take priority over all other inputs in the same cycle.

Structure
REQ-035 Package mandel_pkg SHALL hold CORDW=25, FBITS=21, the coordinate typedef and the FSM state enum.
REQ-036 SHALL contain no sub-module; the iteration engine is instantiated alongside this block by the parent, not inside it.

Verification
REQ-037 Bench SHALL cover a 4x2 frame with re_start=-2.0 (0x1C00000), im_start=1.0 (0x0200000) and step=0x0100000: the 8 writes go to addr 0..7, eng_re of pixel 3 = 0x1F00000, and eng_im of row 1 = 0x0100000.
REQ-038 Bench SHALL cover a stub engine returning iter=N+addr after a 5-cycle delay: fb_data equals that value on every write, and exactly one frame_done follows addr 7.
REQ-039 Bench SHALL cover frame_start pulsed while busy: there is no restart, and the write count stays at FB_WIDTH*FB_HEIGHT.
REQ-040 Bench SHALL cover rst asserted during WAIT at pixel 5: the next cycle shows busy=0, with no fb_we or eng_start until a new frame_start.
REQ-041 Bench SHALL cover a spurious eng_done in IDLE or WRITE: no state change and no extra fb_we.
REQ-042 Bench SHALL cover a 2-cycle engine: ISSUE-to-ISSUE spacing is exactly 6 cycles.

Source files
------------

// File: rtl/mandel_pkg.sv
// Shared types for the Mandelbrot pixel dispatcher: Q4.21 coordinate type
// and the dispatcher FSM state encoding.
package mandel_pkg;

    localparam int CORDW = 25;
    localparam int FBITS = 21;

    typedef logic signed [CORDW-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        WRITE   = 3'd3,
        ADVANCE = 3'd4
    } state_t;

endpackage

// File: rtl/mandel_dispatch.sv
// Walks a frame pixel by pixel in raster order, hands each pixel coordinate to an
// external iteration engine and writes the returned iteration count to the framebuffer.
module mandel_dispatch
    import mandel_pkg::*;
#(
    parameter int FB_WIDTH  = 320,
    parameter int FB_HEIGHT = 180,
    parameter int ITERW     = 8,
    parameter int ADDRW     = $clog2(FB_WIDTH*FB_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic signed [CORDW-1:0] re_start,
    input  logic signed [CORDW-1:0] im_start,
    input  logic signed [CORDW-1:0] step,
    output logic                    eng_start,
    output logic signed [CORDW-1:0] eng_re,
    output logic signed [CORDW-1:0] eng_im,
    input  logic [ITERW-1:0]        eng_iter,
    input  logic                    eng_done,
    output logic                    fb_we,
    output logic [ADDRW-1:0]        fb_addr,
    output logic [ITERW-1:0]        fb_data,
    output logic                    busy,
    output logic                    frame_done,
    output logic [2:0]              dbg_state
);

    localparam int XW = (FB_WIDTH  > 1) ? $clog2(FB_WIDTH)  : 1;
    localparam int YW = (FB_HEIGHT > 1) ? $clog2(FB_HEIGHT) : 1;

    // Handshake: eng_start is a single-cycle request with eng_re/eng_im valid and held
    // until ADVANCE; the engine answers with a single-cycle eng_done carrying eng_iter.
    // eng_done outside WAIT is treated as noise.

    state_t          state, state_nxt;
    logic [XW-1:0]   x;
    logic [YW-1:0]   y;
    coord_t          re0_q;
    coord_t          step_q;
    logic            row_end;
    logic            frame_end;

    assign row_end   = (x == XW'(FB_WIDTH - 1));
    assign frame_end = row_end && (y == YW'(FB_HEIGHT - 1));
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        eng_start  = 1'b0;
        fb_we      = 1'b0;
        frame_done = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (frame_start) state_nxt = ISSUE;
            ISSUE: begin
                eng_start = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:    if (eng_done) state_nxt = WRITE;
            WRITE: begin
                fb_we     = 1'b1;
                state_nxt = ADVANCE;
            end
            ADVANCE: begin
                if (frame_end) begin
                    frame_done = 1'b1;
                    state_nxt  = IDLE;
                end else begin
                    state_nxt  = ISSUE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Coordinates step incrementally; 25-bit adds wrap by construction.
    always_ff @(posedge clk) begin
        if (rst) begin
            x       <= '0;
            y       <= '0;
            fb_addr <= '0;
            fb_data <= '0;
            eng_re  <= '0;
            eng_im  <= '0;
            re0_q   <= '0;
            step_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        re0_q   <= re_start;
                        step_q  <= step;
                        eng_re  <= re_start;
                        eng_im  <= im_start;
                        x       <= '0;
                        y       <= '0;
                        fb_addr <= '0;
                    end
                end
                WAIT: begin
                    if (eng_done) fb_data <= eng_iter;
                end
                ADVANCE: begin
                    if (!row_end) begin
                        x       <= x + XW'(1);
                        eng_re  <= eng_re + step_q;
                        fb_addr <= fb_addr + ADDRW'(1);
                    end else if (!frame_end) begin
                        x       <= '0;
                        y       <= y + YW'(1);
                        eng_re  <= re0_q;
                        eng_im  <= eng_im - step_q;
                        fb_addr <= fb_addr + ADDRW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
